md_issue_seq: RTL and testbench

MD_ISSUE_SEQ -- requirements
Module: md_issue_seq

---
 rtl/md_issue_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_md_issue_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_seq.sv
// ---------------------------------------------------------------------------
// md_issue_seq
//
// Issue sequencer and result buffer in front of a shared multiplier/divider.
// Requests are accepted with a valid/ready handshake and are forwarded
// combinationally to the arithmetic units, which get a one-cycle enable
// pulse. Each unit may have one operation in flight; the tag of that
// operation is held locally until the unit reports completion. Results are
// then buffered together with their tags in a small FIFO and returned on
// the rsp_* handshake.
//
// Before a request is accepted, FIFO space is reserved for every in-flight
// operation. A result therefore always has a slot when it arrives, and the
// units never need to be back-pressured.
//
// Parameters
//   TagW      request/response tag width
//   ResDepth  result FIFO depth (power of two, >= 2)
//
// Configuration macro
//   MD_INTERLEAVE_EN  defined:   a MULL/MULH may issue while a division is
//                                running, so results can return out of tag
//                                order.
//                     undefined: only one operation is outstanding at any
//                                time, and results return in request order.
//
// Ports
//   clk_i, rst_ni           rising-edge clock, synchronous active-low reset
//   req_valid_i/ready_o     request handshake
//   req_op_i                MULL / MULH / DIV / REM
//   req_signed_i            signed mode {b, a}
//   req_a_i, req_b_i        operands
//   req_tag_i               request tag
//   data_ind_timing_i       divider timing mode (the divider samples it
//                           directly in this integration)
//   flush_i                 drop every buffered and in-flight result
//   md_mult_en_o            multiplier start pulse
//   md_div_en_o             divider start pulse
//   md_operator_o           operator, passed through from req_op_i
//   md_signed_mode_o        signed mode, passed through from req_signed_i
//   md_op_a_o, md_op_b_o    operands, passed through from req_a_i/req_b_i
//   md_mult_valid_i/result  multiplier completion (one cycle after start)
//   md_div_valid_i/result   divider completion
//   rsp_valid_o/ready_i     response handshake
//   rsp_data_o, rsp_tag_o   FIFO head
//   busy_o                  a result is in flight or buffered
// ---------------------------------------------------------------------------

package super_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module md_issue_seq
  import super_pkg::*;
#(
  parameter int unsigned TagW     = 5,
  parameter int unsigned ResDepth = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  md_op_e          req_op_i,
  input  logic [1:0]      req_signed_i,
  input  logic [31:0]     req_a_i,
  input  logic [31:0]     req_b_i,
  input  logic [TagW-1:0] req_tag_i,

  input  logic            data_ind_timing_i,
  input  logic            flush_i,

  output logic            md_mult_en_o,
  output logic            md_div_en_o,
  output md_op_e          md_operator_o,
  output logic [1:0]      md_signed_mode_o,
  output logic [31:0]     md_op_a_o,
  output logic [31:0]     md_op_b_o,

  input  logic            md_mult_valid_i,
  input  logic [31:0]     md_mult_result_i,
  input  logic            md_div_valid_i,
  input  logic [31:0]     md_div_result_i,

  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_data_o,
  output logic [TagW-1:0] rsp_tag_o,
  output logic            busy_o
);

  localparam int unsigned PtrW = (ResDepth > 1) ? $clog2(ResDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  // One extra bit so that count plus both in-flight reservations cannot wrap.
  localparam logic [CntW:0] DepthLim = (CntW+1)'(ResDepth);

  // Unit tracking state
  logic            mult_inflight_q;
  logic            div_busy_q;
  logic            mult_discard_q;
  logic            div_discard_q;
  logic [TagW-1:0] mult_tag_q;
  logic [TagW-1:0] div_tag_q;

  // Result FIFO
  logic [31:0]     res_data_q [ResDepth];
  logic [TagW-1:0] res_tag_q  [ResDepth];
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;

  // Combinational control
  logic            is_mul_op;
  logic            unit_free;
  logic            room_ok;
  logic [CntW:0]   occupancy;
  logic            accept;
  logic            mult_push;
  logic            div_push;
  logic [1:0]      push_cnt;
  logic [PtrW-1:0] mult_slot;
  logic            pop;

  // The divider reads the timing mode straight from the core, so this
  // input is kept on the boundary only for interface compatibility.
  logic            unused_data_ind_timing;
  assign unused_data_ind_timing = data_ind_timing_i;

  // ---- Issue stage: operand forwarding and accept decision ----------------

  assign md_operator_o    = req_op_i;
  assign md_signed_mode_o = req_signed_i;
  assign md_op_a_o        = req_a_i;
  assign md_op_b_o        = req_b_i;

  assign is_mul_op = (req_op_i == MD_OP_MULL) || (req_op_i == MD_OP_MULH);

  // Reserve a FIFO slot for each operation that is still computing.
  assign occupancy = {1'b0, count_q}
                   + (CntW+1)'(mult_inflight_q)
                   + (CntW+1)'(div_busy_q);
  assign room_ok   = (occupancy < DepthLim);

`ifdef MD_INTERLEAVE_EN
  // Each unit has one tag register, so a unit accepts a new operation only
  // after its previous result has come back.
  assign unit_free = is_mul_op ? ~mult_inflight_q : ~div_busy_q;
`else
  assign unit_free = ~mult_inflight_q & ~div_busy_q;
`endif

  assign req_ready_o  = rst_ni & ~flush_i & room_ok & unit_free;
  assign accept       = req_valid_i & req_ready_o;
  assign md_mult_en_o = accept & is_mul_op;
  assign md_div_en_o  = accept & ~is_mul_op;

  // ---- Completion stage: results enter the FIFO ---------------------------

  // A completion is accepted only when the unit has a live operation. This
  // drops completions of discarded operations, results that arrive while a
  // flush empties the FIFO, and stray valids that arrive after a reset.
  assign mult_push = md_mult_valid_i & mult_inflight_q & ~mult_discard_q & ~flush_i;
  assign div_push  = md_div_valid_i  & div_busy_q      & ~div_discard_q  & ~flush_i;
  assign push_cnt  = {1'b0, mult_push} + {1'b0, div_push};

  // If both units complete in the same cycle, the divider result takes the
  // first slot and the multiplier result the next one.
  assign mult_slot = wr_ptr_q + PtrW'(div_push);

  // ---- Response stage: FIFO head --------------------------------------------

  assign rsp_valid_o = rst_ni & (count_q != '0);
  assign rsp_data_o  = res_data_q[rd_ptr_q];
  assign rsp_tag_o   = res_tag_q[rd_ptr_q];
  assign pop         = rsp_valid_o & rsp_ready_i;

  assign busy_o = rst_ni & ((count_q != '0) | mult_inflight_q | div_busy_q);

  // Control state: in-flight flags, discard flags, and FIFO occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mult_inflight_q <= 1'b0;
      div_busy_q      <= 1'b0;
      mult_discard_q  <= 1'b0;
      div_discard_q   <= 1'b0;
      count_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
    end else begin
      if (md_mult_en_o) begin
        mult_inflight_q <= 1'b1;
      end else if (md_mult_valid_i) begin
        mult_inflight_q <= 1'b0;
      end

      if (md_div_en_o) begin
        div_busy_q <= 1'b1;
      end else if (md_div_valid_i) begin
        div_busy_q <= 1'b0;
      end

      // Issue is blocked while flush_i is high, so a discard flag never
      // applies to an operation that starts in the flush cycle. A unit that
      // completes during the flush cycle is already dropped by the push
      // gating and needs no flag.
      if (flush_i) begin
        mult_discard_q <= mult_inflight_q & ~md_mult_valid_i;
      end else if (md_mult_valid_i) begin
        mult_discard_q <= 1'b0;
      end

      if (flush_i) begin
        div_discard_q <= div_busy_q & ~md_div_valid_i;
      end else if (md_div_valid_i) begin
        div_discard_q <= 1'b0;
      end

      if (flush_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q  <= count_q + CntW'(push_cnt) - CntW'(pop);
        wr_ptr_q <= wr_ptr_q + PtrW'(push_cnt);
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Datapath state. These registers are not reset: each value is written
  // before anything reads it.
  always_ff @(posedge clk_i) begin
    if (md_mult_en_o) begin
      mult_tag_q <= req_tag_i;
    end
    if (md_div_en_o) begin
      div_tag_q <= req_tag_i;
    end
    if (div_push) begin
      res_data_q[wr_ptr_q] <= md_div_result_i;
      res_tag_q[wr_ptr_q]  <= div_tag_q;
    end
    if (mult_push) begin
      res_data_q[mult_slot] <= md_mult_result_i;
      res_tag_q[mult_slot]  <= mult_tag_q;
    end
  end

endmodule

// File: tb/tb_md_issue_seq.sv
// Directed bench for md_issue_seq. It includes a behavioural
// multiplier/divider (the multiplier has one cycle of latency; the divider
// takes several cycles). Each accepted request pushes its hand-computed
// result into a queue, and a monitor compares every response handshake
// against the head of that queue.
module tb_md_issue_seq;
  import super_pkg::*;

  localparam int TAGW    = 5;
  localparam int DIV_LAT = 6;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  md_op_e          req_op = MD_OP_MULL;
  logic [1:0]      req_signed = 2'b00;
  logic [31:0]     req_a = '0;
  logic [31:0]     req_b = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic            flush = 1'b0;
  logic            rsp_ready = 1'b1;

  logic            md_mult_en, md_div_en;
  md_op_e          md_operator;
  logic [1:0]      md_signed_mode;
  logic [31:0]     md_op_a, md_op_b;
  logic            mult_valid, div_valid;
  logic [31:0]     mult_res, div_res;
  logic            rsp_valid, busy;
  logic [31:0]     rsp_data;
  logic [TAGW-1:0] rsp_tag;
  int              div_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0]     data;
    logic [TAGW-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  md_issue_seq #(.TagW(TAGW), .ResDepth(4)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_op_i          (req_op),
    .req_signed_i      (req_signed),
    .req_a_i           (req_a),
    .req_b_i           (req_b),
    .req_tag_i         (req_tag),
    .data_ind_timing_i (1'b0),
    .flush_i           (flush),
    .md_mult_en_o      (md_mult_en),
    .md_div_en_o       (md_div_en),
    .md_operator_o     (md_operator),
    .md_signed_mode_o  (md_signed_mode),
    .md_op_a_o         (md_op_a),
    .md_op_b_o         (md_op_b),
    .md_mult_valid_i   (mult_valid),
    .md_mult_result_i  (mult_res),
    .md_div_valid_i    (div_valid),
    .md_div_result_i   (div_res),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_data_o        (rsp_data),
    .rsp_tag_o         (rsp_tag),
    .busy_o            (busy)
  );

  // Behavioural arithmetic units.
  function automatic logic [31:0] mul_model(md_op_e op, logic [1:0] sm,
                                            logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (op == MD_OP_MULH) ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [31:0] div_model(md_op_e op, logic [31:0] a, logic [31:0] b);
    if (b == 0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
    return (op == MD_OP_DIV) ? a / b : a % b;
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      mult_valid <= 1'b0;
      div_valid  <= 1'b0;
      div_cnt    <= 0;
    end else begin
      mult_valid <= md_mult_en;
      if (md_mult_en) mult_res <= mul_model(md_operator, md_signed_mode, md_op_a, md_op_b);
      div_valid <= 1'b0;
      if (md_div_en) begin
        div_cnt <= DIV_LAT;
        div_res <= div_model(md_operator, md_op_a, md_op_b);
      end else if (div_cnt != 0) begin
        div_cnt <= div_cnt - 1;
        if (div_cnt == 1) div_valid <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_ni && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got tag %0d data 0x%0h, required no response",
                 rsp_tag, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [TAGW-1:0] t);
    exp_t e;
    e.data = d;
    e.tag  = t;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge.
  task automatic drive(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAGW-1:0] t);
    req_op = op; req_signed = sm; req_a = a; req_b = b; req_tag = t;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(input logic [31:0] d, input logic [TAGW-1:0] t, input bit push);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        if (push) push_exp(d, t);
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hold_bad, seen, stall_bad;

    // Reset: a pending MULL request must not produce any output.
    drive(MD_OP_MULL, 2'b00, 32'd1, 32'd1, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mult_en", 32'(md_mult_en), 32'd0);
    check("rst_div_en", 32'(md_div_en), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_ni = 1'b1;

    // Signed MULL: the enable pulses in cycle 0 and the response is valid in cycle 2.
    drive(MD_OP_MULL, 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd3);
    @(negedge clk);
    check("mull_en_pulse", 32'(md_mult_en), 32'd1);
    check("op_a_pass", md_op_a, 32'hFFFF_FFFF);
    check("signed_pass", 32'(md_signed_mode), 32'd3);
    if (req_ready) push_exp(32'hFFFF_FFFE, 5'd3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mull_lat_c1", 32'(rsp_valid), 32'd0);
    check("mull_en_single", 32'(md_mult_en), 32'd0);
    @(negedge clk);
    check("mull_lat_c2", 32'(rsp_valid), 32'd1);
    wait_idle();

    // DIV 100/7; a following REM is held until the divider reports valid.
    @(posedge clk); #1;
    drive(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd1);
    wait_accept(32'd14, 5'd1, 1'b1);
    drive(MD_OP_REM, 2'b00, 32'd100, 32'd7, 5'd4);
    hold_bad = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (div_valid) seen = 1'b1;
      else if (req_ready) hold_bad = 1'b1;
    end
    check("div_valid_seen", 32'(seen), 32'd1);
    check("div2_held", 32'(hold_bad), 32'd0);
    check("div2_held_at_valid", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("div_rsp_next_cycle", 32'(rsp_valid), 32'd1);
    check("div2_ready_after_valid", 32'(req_ready), 32'd1);
    if (req_ready) push_exp(32'd2, 5'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle();

    // DIV followed by a signed MULH. With interleaving, the MULH result
    // returns first.
`ifdef MD_INTERLEAVE_EN
    push_exp(32'h4000_0000, 5'd2);
    push_exp(32'd14, 5'd1);
`else
    push_exp(32'd14, 5'd1);
    push_exp(32'h4000_0000, 5'd2);
`endif
    @(posedge clk); #1;
    drive(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd1);
    wait_accept(32'd14, 5'd1, 1'b0);
    drive(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 5'd2);
    wait_accept(32'h4000_0000, 5'd2, 1'b0);
    wait_idle();

    // Fill the FIFO with rsp_ready low; the fifth request stalls until a pop.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(MD_OP_MULL, 2'b00, 32'(i + 1), 32'd3, 5'(10 + i));
      wait_accept(32'(3 * (i + 1)), 5'(10 + i), 1'b1);
    end
    drive(MD_OP_MULL, 2'b00, 32'd10, 32'd10, 5'd15);
    stall_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready) stall_bad = 1'b1;
    end
    check("full_stall", 32'(stall_bad), 32'd0);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("full_ready_at_pop", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("ready_after_pop", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    drive(MD_OP_MULL, 2'b00, 32'd10, 32'd10, 5'd15);
    wait_accept(32'd100, 5'd15, 1'b1);
    rsp_ready = 1'b1;
    wait_idle();

    // Flush while a MULL result is buffered and a DIV is in flight.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(MD_OP_MULL, 2'b00, 32'd5, 32'd5, 5'd7);
    wait_accept(32'd25, 5'd7, 1'b0);
    drive(MD_OP_DIV, 2'b00, 32'd50, 32'd5, 5'd6);
    wait_accept(32'd10, 5'd6, 1'b0);
    @(negedge clk);
    check("pre_flush_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    req_op = MD_OP_MULL;
    @(negedge clk);
    check("flush_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_empty", 32'(rsp_valid), 32'd0);
    check("flush_busy_div", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (div_valid) seen = 1'b1;
    end
    check("flush_div_valid_seen", 32'(seen), 32'd1);
    check("busy_at_div_valid", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_div", 32'(busy), 32'd0);
    check("div_discarded", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;

    // Reset during a division, then a new MULL is accepted right after release.
    @(posedge clk); #1;
    drive(MD_OP_DIV, 2'b00, 32'd9, 32'd3, 5'd1);
    wait_accept(32'd3, 5'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    drive(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd5);
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    if (req_ready) push_exp(32'd42, 5'd5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
